id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

ID/EX pipeline register for the 5-stage MIPS core, with built-in load-use hazard detection. It captures decoded control, register numbers and operands from ID each cycle and presents them as the E-stage signals. The forwarding unit consumes these signals (RegWriteE, MemtoRegE, rwE). When an E-stage load's destination matches an ID source, the block inserts one bubble and stalls IF/ID, so that MEM/WB forwarding can supply the loaded value afterwards.

## Interface
- DW, 32, datapath width (operands, immediate, PC)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegWriteD, MemtoRegD, MemWriteD, RegDstRtD, ALUSrcD  in  1 each  decoded controls from ID
- ALUCtrlD  in  4  ALU operation
- rsD, rtD, rwD  in  5 each  source and destination register numbers
- rd1D, rd2D, immD, pcD  in  DW each  register-file reads, sign-extended immediate, PC+4
- validD  in  1  the ID slot holds a real instruction
- UsesRtD  in  1  the ID instruction reads rt (R-type, sw, beq)
- hold  in  1  global freeze, e.g. a memory wait
- flushE  in  1  discard the ID instruction (branch/jump resolved)
- RegWriteE, MemtoRegE, MemWriteE, RegDstRtE, ALUSrcE, validE  out  1 each  registered controls
- ALUCtrlE  out  4; rsE, rtE, rwE  out  5 each; rd1E, rd2E, immE, pcE  out  DW each
- stallFD  out  1  combinational; freezes the PC and IF/ID register this cycle
- bubble_cnt  out  32  present only with ID_EX_PERF_CNT_EN

## Operation
- Load-use detect, combinational:
  - luse = validE & MemtoRegE & RegWriteE & (rwE≠0) & validD & ((rwE==rsD) | (UsesRtD & rwE==rtD))
  - stallFD = luse & ~hold
- Update priority on each edge:
  1. hold=1: every E register keeps its value.
  2. flushE=1: load a bubble.
  3. luse=1: load a bubble.
  4. Otherwise: load all D inputs into the matching E registers; validE←validD.
- Bubble contents:
  - All E controls 0, validE=0.
  - rsE, rtE and rwE are 0, so the forwarding unit sees no match.
  - Data fields are 0.
- A bubble never reaches RegWrite/MemWrite, so it has no architectural effect.
- While stallFD=1, ID presents the same instruction again on the next cycle. That instruction is then accepted because the E slot now holds a bubble. Each load therefore costs exactly one bubble.
- flushE together with luse: the result is a single bubble and stallFD still asserts. The fetch unit gives redirect priority over stall.
- rwE=0: never stalls, because $0 is not a hazard.

## Timing
- Latency: one cycle from D input to E output.
- stallFD is valid in the same cycle as the D inputs. It depends only on current E registers and D inputs and has no path from hold to the E registers.
- Reset (asynchronous assert, release synchronized by the top level):
  - All E outputs 0, validE=0, stallFD=0.
  - bubble_cnt=0.
- Reset asserted mid-stall: all state clears immediately and the pending bubble is lost, which is harmless because every E output is 0.
- hold=1 during luse: stallFD=0 and E is frozen. The hazard re-evaluates after hold drops.

## Configuration
- ID_EX_PERF_CNT_EN defined:
  - bubble_cnt increments by 1 on every edge where a bubble is loaded because of luse, with hold=0 and flushE=0.
  - Bubbles loaded by flush are not counted.
  - The count saturates at 32'hFFFF_FFFF and resets to 0.
- ID_EX_PERF_CNT_EN not defined: the bubble_cnt port and the counter are absent; all other behaviour is identical.

## Test plan
- Plain pass: add with rs=1, rt=2, rw=3, rd1=5, rd2=7, validD=1.
  - Next cycle: E outputs equal the inputs.
  - stallFD=0 throughout.
- Load-use: E holds lw with rw=8 (MemtoRegE=1, RegWriteE=1); D holds add with rs=8.
  - stallFD=1.
  - Next edge: validE=0, RegWriteE=0, rwE=0.
  - Following edge: the add is in E, stallFD=0, and bubble_cnt=1 with the macro defined.
- rt-only hazard: lw writes $9; ID holds addi with rt=9 and UsesRtD=0.
  - stallFD=0, no bubble.
  - Repeat with UsesRtD=1: stallFD=1.
- $0 and hold:
  - lw with rw=0 and ID rs=0: no stall.
  - hold=1 for 3 cycles with a load-use pair present: E outputs unchanged, stallFD=0.
  - After hold releases: one bubble.
- Flush + reset:
  - flushE=1 with a valid add in D: next E is a bubble and bubble_cnt is unchanged.
  - Assert rst_n=0 mid-cycle: all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - ID/EX pipeline register bundle: ID-side inputs, E-side outputs, stall/hold/flush
// Optional port bubble_cnt present only with ID_EX_PERF_CNT_EN.
interface id_ex_pipe_reg_if #(parameter int DW = 32);
  logic          RegWriteD, MemtoRegD, MemWriteD, RegDstRtD, ALUSrcD;
  logic [3:0]    ALUCtrlD;
  logic [4:0]    rsD, rtD, rwD;
  logic [DW-1:0] rd1D, rd2D, immD, pcD;
  logic          validD, UsesRtD, hold, flushE;

  logic          RegWriteE, MemtoRegE, MemWriteE, RegDstRtE, ALUSrcE, validE;
  logic [3:0]    ALUCtrlE;
  logic [4:0]    rsE, rtE, rwE;
  logic [DW-1:0] rd1E, rd2E, immE, pcE;
  logic          stallFD;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]   bubble_cnt;
`endif

  modport master (
    output RegWriteD, MemtoRegD, MemWriteD, RegDstRtD, ALUSrcD, ALUCtrlD,
    output rsD, rtD, rwD, rd1D, rd2D, immD, pcD, validD, UsesRtD, hold, flushE,
    input  RegWriteE, MemtoRegE, MemWriteE, RegDstRtE, ALUSrcE, validE, ALUCtrlE,
    input  rsE, rtE, rwE, rd1E, rd2E, immE, pcE, stallFD
`ifdef ID_EX_PERF_CNT_EN
    , input bubble_cnt
`endif
  );

  modport slave (
    input  RegWriteD, MemtoRegD, MemWriteD, RegDstRtD, ALUSrcD, ALUCtrlD,
    input  rsD, rtD, rwD, rd1D, rd2D, immD, pcD, validD, UsesRtD, hold, flushE,
    output RegWriteE, MemtoRegE, MemWriteE, RegDstRtE, ALUSrcE, validE, ALUCtrlE,
    output rsE, rtE, rwE, rd1E, rd2E, immE, pcE, stallFD
`ifdef ID_EX_PERF_CNT_EN
    , output bubble_cnt
`endif
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use bubble insertion
// Optional saturating bubble counter enabled by ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int DW = 32
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_pipe_reg_if.slave  bus
);

  typedef struct packed {
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic          reg_dst_rt;
    logic          alu_src;
    logic          valid;
    logic [3:0]    alu_ctrl;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rw;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } e_slot_t;

  e_slot_t e_q, e_d, d_slot;
  logic    luse;

  always_comb begin
    d_slot = '{reg_write:  bus.RegWriteD,
               mem_to_reg: bus.MemtoRegD,
               mem_write:  bus.MemWriteD,
               reg_dst_rt: bus.RegDstRtD,
               alu_src:    bus.ALUSrcD,
               valid:      bus.validD,
               alu_ctrl:   bus.ALUCtrlD,
               rs:         bus.rsD,
               rt:         bus.rtD,
               rw:         bus.rwD,
               rd1:        bus.rd1D,
               rd2:        bus.rd2D,
               imm:        bus.immD,
               pc:         bus.pcD};
  end

  // A load in E whose result an ID source needs; $0 is never a hazard.
  always_comb begin
    luse = e_q.valid & e_q.mem_to_reg & e_q.reg_write & (e_q.rw != 5'd0) & bus.validD &
           ((e_q.rw == bus.rsD) | (bus.UsesRtD & (e_q.rw == bus.rtD)));
  end

  assign bus.stallFD = luse & ~bus.hold;

  // An all-zero slot is the bubble: no controls, no register matches, no data.
  always_comb begin
    e_d = e_q;
    if (!bus.hold) begin
      if (bus.flushE || luse) begin
        e_d = '0;
      end else begin
        e_d = d_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign bus.RegWriteE = e_q.reg_write;
  assign bus.MemtoRegE = e_q.mem_to_reg;
  assign bus.MemWriteE = e_q.mem_write;
  assign bus.RegDstRtE = e_q.reg_dst_rt;
  assign bus.ALUSrcE   = e_q.alu_src;
  assign bus.validE    = e_q.valid;
  assign bus.ALUCtrlE  = e_q.alu_ctrl;
  assign bus.rsE       = e_q.rs;
  assign bus.rtE       = e_q.rt;
  assign bus.rwE       = e_q.rw;
  assign bus.rd1E      = e_q.rd1;
  assign bus.rd2E      = e_q.rd2;
  assign bus.immE      = e_q.imm;
  assign bus.pcE       = e_q.pc;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Only hazard bubbles count; flush bubbles are a branch cost, not a load cost.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!bus.hold && !bus.flushE && luse && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed and randomized bench for id_ex_pipe_reg against an instruction-slot model
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic        rdst;
    logic        alus;
    logic        v;
    logic [3:0]  alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rwn;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DW(32)) bus ();
  id_ex_pipe_reg #(.DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int    total = 0;
  int    bad = 0;
  slot_t d_in;
  logic  usesrt, hold_in, flush_in;
  slot_t m_e;
  int unsigned m_cnt;
  bit    last_stall;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t mk_add(input int rs, input int rt, input int rw,
                                   input int unsigned a, input int unsigned b);
    slot_t s = '0;
    s.rw = 1; s.v = 1; s.alu = 4'd2;
    s.rs = 5'(rs); s.rt = 5'(rt); s.rwn = 5'(rw);
    s.rd1 = a; s.rd2 = b; s.pc = 32'h100;
    return s;
  endfunction

  function automatic slot_t mk_lw(input int rs, input int rw);
    slot_t s = '0;
    s.rw = 1; s.mtr = 1; s.alus = 1; s.v = 1; s.alu = 4'd2;
    s.rs = 5'(rs); s.rwn = 5'(rw); s.imm = 32'h4; s.pc = 32'h200;
    return s;
  endfunction

  function automatic slot_t obs_e();
    slot_t s;
    s.rw = bus.RegWriteE; s.mtr = bus.MemtoRegE; s.mw = bus.MemWriteE;
    s.rdst = bus.RegDstRtE; s.alus = bus.ALUSrcE; s.v = bus.validE;
    s.alu = bus.ALUCtrlE; s.rs = bus.rsE; s.rt = bus.rtE; s.rwn = bus.rwE;
    s.rd1 = bus.rd1E; s.rd2 = bus.rd2E; s.imm = bus.immE; s.pc = bus.pcE;
    return s;
  endfunction

  // The instruction in E is a load whose destination the ID instruction reads.
  function automatic bit m_hazard();
    bit is_load = m_e.v && m_e.mtr && m_e.rw;
    bit reads = (m_e.rwn == d_in.rs) || (usesrt && m_e.rwn == d_in.rt);
    return is_load && (m_e.rwn != 0) && d_in.v && reads;
  endfunction

  task automatic apply();
    bus.RegWriteD = d_in.rw; bus.MemtoRegD = d_in.mtr; bus.MemWriteD = d_in.mw;
    bus.RegDstRtD = d_in.rdst; bus.ALUSrcD = d_in.alus; bus.validD = d_in.v;
    bus.ALUCtrlD = d_in.alu; bus.rsD = d_in.rs; bus.rtD = d_in.rt; bus.rwD = d_in.rwn;
    bus.rd1D = d_in.rd1; bus.rd2D = d_in.rd2; bus.immD = d_in.imm; bus.pcD = d_in.pc;
    bus.UsesRtD = usesrt; bus.hold = hold_in; bus.flushE = flush_in;
  endtask

  task automatic cycle(input string tag);
    bit haz;
    slot_t nxt;
    apply();
    #1;
    haz = m_hazard();
    last_stall = haz && !hold_in;
    chk({tag, ".stall"}, bus.stallFD, last_stall);
    nxt = m_e;
    if (!hold_in) begin
      if (flush_in || haz) nxt = '0;
      else nxt = d_in;
      if (haz && !flush_in && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
    @(posedge clk);
    #1;
    m_e = nxt;
    chk({tag, ".e"}, obs_e(), m_e);
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".cnt"}, bus.bubble_cnt, m_cnt);
`endif
    @(negedge clk);
  endtask

  initial begin
    d_in = '0; usesrt = 0; hold_in = 0; flush_in = 0;
    m_e = '0; m_cnt = 0;
    apply();
    repeat (2) @(negedge clk);
    chk("reset.e", obs_e(), slot_t'(0));
    chk("reset.stall", bus.stallFD, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    chk("reset.cnt", bus.bubble_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // plain pass
    d_in = mk_add(1, 2, 3, 5, 7); usesrt = 1;
    cycle("pass");
    chk("pass.rd2", bus.rd2E, 32'd7);

    // load-use on rs
    d_in = mk_lw(1, 8); cycle("lu.lw");
    d_in = mk_add(8, 2, 4, 1, 1);
    cycle("lu.hit");
    chk("lu.stall_seen", last_stall, 1'b1);
    chk("lu.bubble", {bus.validE, bus.RegWriteE, bus.rwE}, 7'd0);
    cycle("lu.accept");
    chk("lu.add_in_e", {bus.validE, bus.rsE}, {1'b1, 5'd8});

    // rt-only hazard, gated by UsesRtD
    d_in = mk_lw(1, 9); usesrt = 1; cycle("rt.lw");
    d_in = mk_add(1, 9, 10, 3, 3); d_in.alus = 1; usesrt = 0;
    cycle("rt.nouse");
    d_in = mk_lw(1, 9); usesrt = 1; cycle("rt.lw2");
    d_in = mk_add(1, 9, 10, 3, 3); d_in.alus = 1; usesrt = 1;
    cycle("rt.use");
    cycle("rt.accept");

    // $0 destination never stalls
    d_in = mk_lw(1, 0); cycle("z.lw");
    d_in = mk_add(0, 0, 5, 2, 2); cycle("z.use");

    // hold freezes E and masks stall, hazard resolves after release
    d_in = mk_lw(2, 8); cycle("h.lw");
    d_in = mk_add(8, 1, 6, 9, 9); hold_in = 1;
    for (int i = 0; i < 3; i++) cycle("h.frozen");
    hold_in = 0;
    cycle("h.release");
    cycle("h.accept");

    // flush with a valid instruction in D
    d_in = mk_add(1, 2, 3, 4, 5); flush_in = 1;
    cycle("flush");
    // flush coinciding with load-use: one bubble, stall still asserted
    flush_in = 0; d_in = mk_lw(1, 7); cycle("fl.lw");
    d_in = mk_add(7, 1, 2, 0, 0); flush_in = 1;
    cycle("fl.luse");
    flush_in = 0;
    cycle("fl.after");

    // randomized traffic; ID re-presents its instruction while stalled or held
    for (int n = 0; n < 400; n++) begin
      if (!(last_stall || hold_in)) begin
        if ($urandom_range(0, 9) < 4) d_in = mk_lw($urandom_range(0, 3), $urandom_range(0, 3));
        else d_in = mk_add($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom, $urandom);
        d_in.v = ($urandom_range(0, 9) != 0);
        d_in.imm = $urandom; d_in.pc = $urandom;
        usesrt = 1'($urandom_range(0, 1));
      end
      hold_in = ($urandom_range(0, 7) == 0);
      flush_in = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    // reset asserted mid-cycle while a load-use stall is pending
    hold_in = 0; flush_in = 0; usesrt = 1;
    d_in = mk_lw(1, 5); cycle("rst.lw");
    d_in = mk_add(5, 1, 2, 3, 4); apply();
    #2;
    chk("rst.pre_stall", bus.stallFD, 1'b1);
    rst_n = 1'b0;
    #1;
    m_e = '0; m_cnt = 0;
    chk("rst.async_e", obs_e(), slot_t'(0));
    chk("rst.async_stall", bus.stallFD, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    chk("rst.async_cnt", bus.bubble_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
